ovi_core_master: RTL and testbench

//  Core-side end of the OVI link: issues one vector instruction at a time to the VPU.

---
 rtl/ovi_pkg.sv | 84 ++++++++
 rtl/ovi_credit_counter.sv | 36 +++
 rtl/ovi_core_master.sv | 198 +++++++++++++++++++
 tb/tb_ovi_core_master.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovi_pkg.sv
// Shared OVI definitions: VPU bus structs, memop opcodes, VPU_LOAD seq_id layout
// and the core-master FSM states.
package ovi_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;

    localparam int SEQ_W         = 34;
    localparam int SEQ_VREG_LSB  = 0;
    localparam int SEQ_ELID_LSB  = 5;
    localparam int SEQ_OFF_LSB   = 16;
    localparam int SEQ_ELCNT_LSB = 22;
    localparam int SEQ_SB_LSB    = 29;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT_SYNC,
        ST_LOAD_XFER,
        ST_STORE_XFER,
        ST_SYNC_END,
        ST_WAIT_CMPL
    } ovi_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] scalar_opnd;
        logic [4:0]  sb_id;
    } vpu_issue_bus;

    typedef struct packed {
        logic       valid;
        logic [4:0] sb_id;
        logic       next_senior;
        logic       kill;
    } vpu_dispatch_bus;

    typedef struct packed {
        logic        valid;
        logic [4:0]  sb_id;
        logic [4:0]  fflags;
        logic        illegal;
        logic [63:0] dest_reg;
    } vpu_completed_bus;

    typedef struct packed {
        logic       sync_end;
        logic [4:0] sb_id;
    } vpu_memop_bus;

    typedef struct packed {
        logic             valid;
        logic [511:0]     data;
        logic [SEQ_W-1:0] seq_id;
    } vpu_load_bus;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } vpu_store_bus;

    typedef struct packed {
        logic        valid;
        logic [64:0] item;
        logic        last_idx;
    } vpu_mask_idx_bus;

    // The byte offset field is always zero: beats are element aligned.
    function automatic logic [SEQ_W-1:0] makeSeqId(input logic [4:0]  vreg,
                                                   input logic [10:0] elId,
                                                   input logic [6:0]  elCount,
                                                   input logic [4:0]  sbId);
        logic [SEQ_W-1:0] seq;
        seq                       = '0;
        seq[SEQ_VREG_LSB +: 5]    = vreg;
        seq[SEQ_ELID_LSB +: 11]   = elId;
        seq[SEQ_OFF_LSB +: 6]     = 6'd0;
        seq[SEQ_ELCNT_LSB +: 7]   = elCount;
        seq[SEQ_SB_LSB +: 5]      = sbId;
        return seq;
    endfunction

endpackage

// File: rtl/ovi_credit_counter.sv
// Saturating up/down credit counter; a simultaneous increment and decrement cancel out.
module ovi_credit_counter
#(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CNT_W'(MAX_COUNT)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ovi_core_master.sv
// Core-side OVI master: issues one vector instruction at a time, sequences the
// load/store beats of memops and returns the VPU completion to the scalar pipe.
module ovi_core_master
    import ovi_pkg::*;
#(
    parameter int MAX_ISSUE_CREDITS = 4,
    parameter int EL_PER_BEAT       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             core_req_valid,
    output logic             core_req_ready,
    input  logic [31:0]      core_req_instr,
    input  logic [63:0]      core_req_opnd,
    input  logic [5:0]       core_req_beats,
    output logic             core_cmpl_valid,
    output logic [63:0]      core_cmpl_dest,
    output logic             core_cmpl_illegal,
    output logic [4:0]       core_cmpl_fflags,
    input  logic             lsu_ld_valid,
    output logic             lsu_ld_ready,
    input  logic [511:0]     lsu_ld_data,
    output logic             lsu_st_valid,
    output logic [511:0]     lsu_st_data,
    output logic             err_sb_mismatch,
    output vpu_issue_bus     VPU_ISSUE,
    output vpu_dispatch_bus  VPU_DISPATCH,
    output vpu_memop_bus     VPU_MEMOP,
    output vpu_load_bus      VPU_LOAD,
    input  logic             VPU_ISSUE_CREDIT,
    input  vpu_completed_bus VPU_COMPLETED,
    input  logic             VPU_SYNC_START,
    input  vpu_store_bus     VPU_STORE,
    output logic             VPU_STORE_CREDIT,
    input  vpu_mask_idx_bus  VPU_MASK_IDX,
    output logic             VPU_MASK_IDX_CREDIT
);

    localparam int CREDIT_W = $clog2(MAX_ISSUE_CREDITS + 1);

    ovi_state_e state_q, state_d;
    logic [4:0]          sbId_q, sbId_d;
    logic [5:0]          beatCnt_q, beatCnt_d;
    logic [5:0]          beats_q;
    logic [4:0]          vreg_q;
    logic                isLoad_q, isStore_q;
    logic                stValid_q;
    logic [511:0]        stData_q;
    logic                cmplValid_q, cmplIllegal_q, sbErr_q;
    logic [63:0]         cmplDest_q;
    logic [4:0]          cmplFflags_q;
    logic [CREDIT_W-1:0] credits;
    logic                accept, stFire, cmplFire, sbMismatch;
    logic [10:0]         elId;
    logic                unused_maskIdx;

    ovi_credit_counter #(
        .MAX_COUNT (MAX_ISSUE_CREDITS)
    ) u_credits (
        .CLK     (CLK),
        .RST     (RST),
        .inc_i   (VPU_ISSUE_CREDIT),
        .dec_i   (accept),
        .count_o (credits)
    );

    assign elId = 11'(beatCnt_q) * 11'(EL_PER_BEAT);

    always_comb begin
        state_d        = state_q;
        sbId_d         = sbId_q;
        beatCnt_d      = beatCnt_q;
        accept         = 1'b0;
        stFire         = 1'b0;
        cmplFire       = 1'b0;
        sbMismatch     = 1'b0;
        lsu_ld_ready   = 1'b0;
        VPU_ISSUE      = '0;
        VPU_DISPATCH   = '0;
        VPU_MEMOP      = '0;
        VPU_LOAD       = '0;
        case (state_q)
            ST_IDLE: begin
                if (core_req_valid && credits != '0) begin
                    accept                = 1'b1;
                    VPU_ISSUE.valid       = 1'b1;
                    VPU_ISSUE.instr       = core_req_instr;
                    VPU_ISSUE.scalar_opnd = core_req_opnd;
                    VPU_ISSUE.sb_id       = sbId_q;
                    state_d               = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                VPU_DISPATCH.valid       = 1'b1;
                VPU_DISPATCH.sb_id       = sbId_q;
                VPU_DISPATCH.next_senior = 1'b1;
                state_d = (isLoad_q || isStore_q) ? ST_WAIT_SYNC : ST_WAIT_CMPL;
            end
            ST_WAIT_SYNC: begin
                if (VPU_SYNC_START) begin
                    state_d = isLoad_q ? ST_LOAD_XFER : ST_STORE_XFER;
                end
            end
            ST_LOAD_XFER: begin
                lsu_ld_ready = 1'b1;
                if (lsu_ld_valid) begin
                    VPU_LOAD.valid  = 1'b1;
                    VPU_LOAD.data   = lsu_ld_data;
                    VPU_LOAD.seq_id = makeSeqId(vreg_q, elId, 7'(EL_PER_BEAT), sbId_q);
                    beatCnt_d       = beatCnt_q + 6'd1;
                    if (beatCnt_q == beats_q - 6'd1) begin
                        beatCnt_d = '0;
                        state_d   = ST_SYNC_END;
                    end
                end
            end
            ST_STORE_XFER: begin
                if (VPU_STORE.valid) begin
                    stFire    = 1'b1;
                    beatCnt_d = beatCnt_q + 6'd1;
                    if (beatCnt_q == beats_q - 6'd1) begin
                        beatCnt_d = '0;
                        state_d   = ST_SYNC_END;
                    end
                end
            end
            ST_SYNC_END: begin
                VPU_MEMOP.sync_end = 1'b1;
                VPU_MEMOP.sb_id    = sbId_q;
                state_d            = ST_WAIT_CMPL;
            end
            ST_WAIT_CMPL: begin
                if (VPU_COMPLETED.valid) begin
                    cmplFire   = 1'b1;
                    sbMismatch = (VPU_COMPLETED.sb_id != sbId_q);
                    sbId_d     = sbId_q + 5'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A completion with no instruction waiting for it is flagged, never forwarded.
        if (VPU_COMPLETED.valid && state_q != ST_WAIT_CMPL) begin
            sbMismatch = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            sbId_q        <= '0;
            beatCnt_q     <= '0;
            beats_q       <= '0;
            vreg_q        <= '0;
            isLoad_q      <= 1'b0;
            isStore_q     <= 1'b0;
            stValid_q     <= 1'b0;
            stData_q      <= '0;
            cmplValid_q   <= 1'b0;
            cmplDest_q    <= '0;
            cmplIllegal_q <= 1'b0;
            cmplFflags_q  <= '0;
            sbErr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sbId_q      <= sbId_d;
            beatCnt_q   <= beatCnt_d;
            stValid_q   <= stFire;
            stData_q    <= stFire ? VPU_STORE.data : '0;
            cmplValid_q <= cmplFire;
            sbErr_q     <= sbMismatch;
            if (accept) begin
                beats_q   <= core_req_beats;
                vreg_q    <= core_req_instr[11:7];
                isLoad_q  <= (core_req_instr[6:0] == OPC_LOAD);
                isStore_q <= (core_req_instr[6:0] == OPC_STORE);
            end
            if (cmplFire) begin
                cmplDest_q    <= VPU_COMPLETED.dest_reg;
                cmplIllegal_q <= VPU_COMPLETED.illegal;
                cmplFflags_q  <= VPU_COMPLETED.fflags;
            end
        end
    end

    assign core_req_ready      = accept;
    assign core_cmpl_valid     = cmplValid_q;
    assign core_cmpl_dest      = cmplDest_q;
    assign core_cmpl_illegal   = cmplIllegal_q;
    assign core_cmpl_fflags    = cmplFflags_q;
    assign lsu_st_valid        = stValid_q;
    assign lsu_st_data         = stData_q;
    assign VPU_STORE_CREDIT    = stValid_q;
    assign err_sb_mismatch     = sbErr_q;
    assign VPU_MASK_IDX_CREDIT = 1'b0;
    assign unused_maskIdx      = ^VPU_MASK_IDX;

endmodule

// File: tb/tb_ovi_core_master.sv
// Directed-random bench for ovi_core_master; expected values come from a
// transaction-level model (credit count, scoreboard id, seq_id arithmetic).
module tb_ovi_core_master;
    import ovi_pkg::*;

    localparam int MAX_CREDITS = 4;
    localparam int EL_PER_BEAT = 16;

    logic CLK = 1'b0;
    logic RST;
    logic core_req_valid, core_req_ready, core_cmpl_valid, core_cmpl_illegal;
    logic [31:0] core_req_instr;
    logic [63:0] core_req_opnd, core_cmpl_dest;
    logic [5:0] core_req_beats;
    logic [4:0] core_cmpl_fflags;
    logic lsu_ld_valid, lsu_ld_ready, lsu_st_valid, err_sb_mismatch;
    logic [511:0] lsu_ld_data, lsu_st_data;
    vpu_issue_bus VPU_ISSUE;
    vpu_dispatch_bus VPU_DISPATCH;
    vpu_memop_bus VPU_MEMOP;
    vpu_load_bus VPU_LOAD;
    logic VPU_ISSUE_CREDIT, VPU_SYNC_START, VPU_STORE_CREDIT, VPU_MASK_IDX_CREDIT;
    vpu_completed_bus VPU_COMPLETED;
    vpu_store_bus VPU_STORE;
    vpu_mask_idx_bus VPU_MASK_IDX;

    int errorCount = 0;
    int checkCount = 0;
    int modelCredits = 0;
    int modelSb = 0;

    ovi_core_master #(.MAX_ISSUE_CREDITS(MAX_CREDITS), .EL_PER_BEAT(EL_PER_BEAT)) dut (
        .CLK(CLK), .RST(RST),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_instr(core_req_instr), .core_req_opnd(core_req_opnd),
        .core_req_beats(core_req_beats),
        .core_cmpl_valid(core_cmpl_valid), .core_cmpl_dest(core_cmpl_dest),
        .core_cmpl_illegal(core_cmpl_illegal), .core_cmpl_fflags(core_cmpl_fflags),
        .lsu_ld_valid(lsu_ld_valid), .lsu_ld_ready(lsu_ld_ready), .lsu_ld_data(lsu_ld_data),
        .lsu_st_valid(lsu_st_valid), .lsu_st_data(lsu_st_data),
        .err_sb_mismatch(err_sb_mismatch),
        .VPU_ISSUE(VPU_ISSUE), .VPU_DISPATCH(VPU_DISPATCH), .VPU_MEMOP(VPU_MEMOP),
        .VPU_LOAD(VPU_LOAD), .VPU_ISSUE_CREDIT(VPU_ISSUE_CREDIT),
        .VPU_COMPLETED(VPU_COMPLETED), .VPU_SYNC_START(VPU_SYNC_START),
        .VPU_STORE(VPU_STORE), .VPU_STORE_CREDIT(VPU_STORE_CREDIT),
        .VPU_MASK_IDX(VPU_MASK_IDX), .VPU_MASK_IDX_CREDIT(VPU_MASK_IDX_CREDIT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        core_req_valid = 1'b0; core_req_instr = '0; core_req_opnd = '0; core_req_beats = '0;
        lsu_ld_valid = 1'b0; lsu_ld_data = '0; VPU_ISSUE_CREDIT = 1'b0;
        VPU_COMPLETED = '0; VPU_SYNC_START = 1'b0; VPU_STORE = '0; VPU_MASK_IDX = '0;
    endtask

    function automatic logic [511:0] randomBeat();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [31:0] arithInstr();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'h57};
    endfunction

    function automatic logic [31:0] memInstr(input bit isLoad, input logic [4:0] vreg);
        logic [31:0] r;
        r = $urandom;
        return {r[31:12], vreg, (isLoad ? 7'b0000111 : 7'b0100111)};
    endfunction

    // seq_id = vreg + el_id*2^5 + el_count*2^22 + sb_id*2^29, with el_id = beat*EL_PER_BEAT
    function automatic logic [33:0] expectedSeqId(input int vreg, input int beatIdx, input int sb);
        longint s;
        s = longint'(vreg) + longint'(beatIdx * EL_PER_BEAT) * 32
            + longint'(EL_PER_BEAT) * 4194304 + longint'(sb) * 536870912;
        return s[33:0];
    endfunction

    function automatic int nextCredits(input int cur, input bit inc, input bit dec);
        int n;
        n = cur + (inc ? 1 : 0) - (dec ? 1 : 0);
        return (n > MAX_CREDITS) ? MAX_CREDITS : n;
    endfunction

    task automatic giveCredits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            VPU_ISSUE_CREDIT = 1'b1;
            modelCredits = nextCredits(modelCredits, 1'b1, 1'b0);
        end
        @(negedge CLK);
        VPU_ISSUE_CREDIT = 1'b0;
    endtask

    task automatic issueInstr(input logic [31:0] instr, input logic [63:0] opnd,
                              input logic [5:0] beats, input bit creditSame);
        bit accepted = 1'b0;
        bit expReady;
        for (int c = 0; c < 6 && !accepted; c++) begin
            @(negedge CLK);
            core_req_valid = 1'b1; core_req_instr = instr; core_req_opnd = opnd;
            core_req_beats = beats; VPU_ISSUE_CREDIT = creditSame && (c == 0);
            #1;
            expReady = (modelCredits != 0);
            checkOutput("reqReady", core_req_ready, expReady);
            checkOutput("issueValid", VPU_ISSUE.valid, expReady);
            if (expReady) begin
                checkOutput("issueInstr", VPU_ISSUE.instr, instr);
                checkOutput("issueOpnd", VPU_ISSUE.scalar_opnd, opnd);
                checkOutput("issueSbId", VPU_ISSUE.sb_id, modelSb[4:0]);
                accepted = 1'b1;
            end
            modelCredits = nextCredits(modelCredits, VPU_ISSUE_CREDIT, expReady);
        end
        checkOutput("issueAccepted", accepted, 1'b1);
        @(negedge CLK);
        VPU_ISSUE_CREDIT = 1'b0;
        #1;
        checkOutput("dispatchValid", VPU_DISPATCH.valid, 1'b1);
        checkOutput("dispatchSbId", VPU_DISPATCH.sb_id, modelSb[4:0]);
        checkOutput("dispatchSenior", VPU_DISPATCH.next_senior, 1'b1);
        checkOutput("dispatchKill", VPU_DISPATCH.kill, 1'b0);
        checkOutput("readyInDispatch", core_req_ready, 1'b0);
        core_req_valid = 1'b0;
    endtask

    task automatic completeInstr(input logic [4:0] sb, input bit expectCmpl);
        logic [63:0] dest;
        logic [4:0] ff;
        logic ill;
        dest = {$urandom, $urandom};
        ff = 5'($urandom_range(0, 31));
        ill = 1'($urandom_range(0, 1));
        @(negedge CLK);
        VPU_COMPLETED = '{valid: 1'b1, sb_id: sb, fflags: ff, illegal: ill, dest_reg: dest};
        @(negedge CLK);
        VPU_COMPLETED = '0;
        #1;
        checkOutput("cmplValid", core_cmpl_valid, expectCmpl);
        checkOutput("sbMismatch", err_sb_mismatch, expectCmpl ? (sb != 5'(modelSb)) : 1'b1);
        if (expectCmpl) begin
            checkOutput("cmplDest", core_cmpl_dest, dest);
            checkOutput("cmplIllegal", core_cmpl_illegal, ill);
            checkOutput("cmplFflags", core_cmpl_fflags, ff);
            modelSb = (modelSb + 1) % 32;
        end
        @(negedge CLK);
        #1;
        checkOutput("cmplPulseEnd", core_cmpl_valid, 1'b0);
        checkOutput("errPulseEnd", err_sb_mismatch, 1'b0);
    endtask

    task automatic waitSyncThenStart(input int holdCycles);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge CLK);
            lsu_ld_valid = 1'b1;
            #1;
            checkOutput("ldReadyBeforeSync", lsu_ld_ready, 1'b0);
            checkOutput("loadBeforeSync", VPU_LOAD.valid, 1'b0);
        end
        @(negedge CLK);
        lsu_ld_valid = 1'b0;
        VPU_SYNC_START = 1'b1;
        @(posedge CLK);
        #1;
        VPU_SYNC_START = 1'b0;
    endtask

    task automatic loadBeats(input int vreg, input int beats);
        int sent = 0;
        int guard = 0;
        bit gap;
        logic [511:0] beat;
        while (sent < beats && guard < 400) begin
            @(negedge CLK);
            guard++;
            gap = ($urandom_range(0, 3) == 0);
            beat = randomBeat();
            lsu_ld_valid = !gap;
            lsu_ld_data = beat;
            #1;
            checkOutput("ldReady", lsu_ld_ready, 1'b1);
            checkOutput("loadValid", VPU_LOAD.valid, !gap);
            checkOutput("syncEndEarly", VPU_MEMOP.sync_end, 1'b0);
            if (!gap) begin
                checkOutput("loadData", VPU_LOAD.data, beat);
                checkOutput("loadSeqId", VPU_LOAD.seq_id, expectedSeqId(vreg, sent, modelSb));
                sent++;
            end
        end
        checkOutput("loadBeatsSent", sent, beats);
        @(negedge CLK);
        lsu_ld_valid = 1'b0;
        #1;
        checkOutput("loadSyncEnd", VPU_MEMOP.sync_end, 1'b1);
        checkOutput("syncEndSbId", VPU_MEMOP.sb_id, modelSb[4:0]);
        checkOutput("ldReadyAfter", lsu_ld_ready, 1'b0);
        @(negedge CLK);
        #1;
        checkOutput("syncEndPulse", VPU_MEMOP.sync_end, 1'b0);
    endtask

    task automatic storeBeats(input int beats);
        int sent = 0;
        int guard = 0;
        bit gap;
        bit prevValid = 1'b0;
        logic [511:0] prevData = '0;
        logic [511:0] beat;
        while (sent < beats && guard < 400) begin
            @(negedge CLK);
            guard++;
            gap = ($urandom_range(0, 3) == 0);
            beat = randomBeat();
            VPU_STORE = '{valid: !gap, data: beat};
            #1;
            checkOutput("stValid", lsu_st_valid, prevValid);
            checkOutput("stCredit", VPU_STORE_CREDIT, prevValid);
            if (prevValid) checkOutput("stData", lsu_st_data, prevData);
            checkOutput("syncEndEarly", VPU_MEMOP.sync_end, 1'b0);
            prevValid = !gap;
            prevData = beat;
            if (!gap) sent++;
        end
        checkOutput("storeBeatsSent", sent, beats);
        @(negedge CLK);
        VPU_STORE = '0;
        #1;
        checkOutput("stValidLast", lsu_st_valid, prevValid);
        checkOutput("stCreditLast", VPU_STORE_CREDIT, prevValid);
        checkOutput("stDataLast", lsu_st_data, prevData);
        checkOutput("storeSyncEnd", VPU_MEMOP.sync_end, 1'b1);
        @(negedge CLK);
        #1;
        checkOutput("stValidEnd", lsu_st_valid, 1'b0);
        checkOutput("syncEndPulse", VPU_MEMOP.sync_end, 1'b0);
    endtask

    initial begin
        int n;
        RST = 1'b1;
        clearInputs();
        core_req_valid = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("rstReqReady", core_req_ready, 1'b0);
        checkOutput("rstIssueValid", VPU_ISSUE.valid, 1'b0);
        checkOutput("rstCmplValid", core_cmpl_valid, 1'b0);
        checkOutput("rstCmplDest", core_cmpl_dest, 64'd0);
        checkOutput("rstStValid", lsu_st_valid, 1'b0);
        checkOutput("rstSyncEnd", VPU_MEMOP.sync_end, 1'b0);
        checkOutput("rstMaskCredit", VPU_MASK_IDX_CREDIT, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] no credits: request must stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checkOutput("noCreditReady", core_req_ready, 1'b0);
        end
        core_req_valid = 1'b0;

        $display("[TB] arithmetic issue and completion");
        issueInstr(32'h02008057, {$urandom, $urandom}, 6'd1, 1'b1);
        completeInstr(5'd0, 1'b1);
        issueInstr(arithInstr(), {$urandom, $urandom}, 6'd1, 1'b1);
        completeInstr(5'(modelSb), 1'b1);
        issueInstr(arithInstr(), {$urandom, $urandom}, 6'd1, 1'b1);
        completeInstr(5'(modelSb) ^ 5'h3, 1'b1);
        completeInstr(5'(modelSb), 1'b0);

        $display("[TB] store beat outside a transfer is dropped");
        @(negedge CLK);
        VPU_STORE = '{valid: 1'b1, data: randomBeat()};
        @(negedge CLK);
        VPU_STORE = '0;
        #1;
        checkOutput("dropStValid", lsu_st_valid, 1'b0);
        checkOutput("dropStCredit", VPU_STORE_CREDIT, 1'b0);

        $display("[TB] loads");
        issueInstr(memInstr(1'b1, 5'd3), {$urandom, $urandom}, 6'd2, 1'b1);
        waitSyncThenStart(2);
        loadBeats(3, 2);
        completeInstr(5'(modelSb), 1'b1);
        for (int k = 0; k < 3; k++) begin
            int vreg = $urandom_range(0, 31);
            int beats = (k == 0) ? 32 : (k == 1) ? 1 : $urandom_range(2, 8);
            issueInstr(memInstr(1'b1, 5'(vreg)), {$urandom, $urandom}, 6'(beats), 1'b1);
            waitSyncThenStart(1);
            loadBeats(vreg, beats);
            completeInstr(5'(modelSb), 1'b1);
        end

        $display("[TB] stores");
        issueInstr(memInstr(1'b0, 5'd7), {$urandom, $urandom}, 6'd3, 1'b1);
        waitSyncThenStart(1);
        storeBeats(3);
        completeInstr(5'(modelSb), 1'b1);
        n = $urandom_range(1, 6);
        issueInstr(memInstr(1'b0, 5'($urandom_range(0, 31))), {$urandom, $urandom}, 6'(n), 1'b1);
        waitSyncThenStart(0);
        storeBeats(n);
        completeInstr(5'(modelSb), 1'b1);

        $display("[TB] credit saturation");
        giveCredits(6);
        for (int k = 0; k < 5; k++) begin
            issueInstr(arithInstr(), {$urandom, $urandom}, 6'd1, 1'b0);
            completeInstr(5'(modelSb), 1'b1);
            if (modelCredits == 0) break;
        end
        core_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checkOutput("saturatedReady", core_req_ready, modelCredits != 0);
        end
        core_req_valid = 1'b0;

        $display("[TB] reset during load transfer");
        giveCredits(2);
        issueInstr(memInstr(1'b1, 5'd9), {$urandom, $urandom}, 6'd4, 1'b0);
        waitSyncThenStart(0);
        @(negedge CLK);
        lsu_ld_valid = 1'b1;
        lsu_ld_data = randomBeat();
        #1;
        checkOutput("preRstLoadValid", VPU_LOAD.valid, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("midRstLoadValid", VPU_LOAD.valid, 1'b0);
        checkOutput("midRstLdReady", lsu_ld_ready, 1'b0);
        checkOutput("midRstSyncEnd", VPU_MEMOP.sync_end, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        clearInputs();
        modelCredits = 0;
        modelSb = 0;
        core_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checkOutput("postRstSyncEnd", VPU_MEMOP.sync_end, 1'b0);
            checkOutput("postRstReady", core_req_ready, 1'b0);
        end
        core_req_valid = 1'b0;

        $display("[TB] 33 back-to-back instructions");
        for (int k = 0; k < 33; k++) begin
            issueInstr(arithInstr(), {$urandom, $urandom}, 6'd1, 1'b1);
            completeInstr(5'(modelSb), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
